coin_debounce: RTL
==================

// Module: coin_debounce
// PURPOSE
//  Front-end conditioner for the coin-acceptor switch, directly upstream of the coin
//  colour-classifier FSM. It does three things to the asynchronous, bouncy coin_raw contact:
//  - synchronises it into clk;
//  - debounces it with a 4-state FSM plus stability counter;
//  - emits exactly one single-cycle `coin` pulse per accepted insertion.
//  The classifier counts those pulses in its 3-cycle window. It has no tolerance for bounce
//  or multi-cycle pulses.
// PARAMETERS
//  DEB_CYCLES  4        consecutive synchronised cycles a level must hold to be accepted (>=1)
//  CNT_W       derived  localparam, $clog2(DEB_CYCLES)+1; width of stability counter
// PORTS
//  clk         in   1  single system clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  coin_raw    in   1  raw coin switch, asynchronous to clk, may bounce
//  coin        out  1  registered 1-cycle pulse per accepted insertion; feeds classifier `coin`
//  coin_level  out  1  registered debounced level (1 while coin accepted as present)
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge) clears everything to 0:
//    - sync0, sync1, cnt, coin and coin_level are 0;
//    - state is IDLE.
//    Reset has priority over all other logic.
//  - Sync: sync0<=coin_raw; sync1<=sync0. The FSM sees only sync1.
//  - FSM states: IDLE(00) RISE_CHK(01) HIGH(10) FALL_CHK(11).
//  - IDLE: sync1=1 -> RISE_CHK, cnt<=0. Otherwise stay.
//  - RISE_CHK:
//    - sync1=0 -> IDLE (glitch rejected, no pulse);
//    - sync1=1 and cnt==DEB_CYCLES-1 -> HIGH, coin<=1;
//    - otherwise cnt<=cnt+1.
//  - HIGH: sync1=0 -> FALL_CHK, cnt<=0. Otherwise stay.
//  - FALL_CHK:
//    - sync1=1 -> HIGH (release bounce, NO new pulse);
//    - sync1=0 and cnt==DEB_CYCLES-1 -> IDLE;
//    - otherwise cnt<=cnt+1.
//  - coin is 1 only in the cycle following the RISE_CHK->HIGH edge. It is 0 on every other
//    cycle, so it is never high two cycles in a row.
//  - coin_level <= 1 when next state is HIGH or FALL_CHK, else 0. It rises on the same edge as coin.
//  - Latency: coin_raw first sampled high at edge N, and steady. Then:
//    - sync1=1 at edge N+1;
//    - state RISE_CHK at edge N+2;
//    - coin and coin_level go 1 at edge N+2+DEB_CYCLES. With DEB_CYCLES=4 that is 6 edges.
//  - Release latency is symmetric: coin_level falls DEB_CYCLES+2 edges after coin_raw is
//    first sampled low.
//  - A high run shorter than DEB_CYCLES+1 synchronised cycles never produces a pulse.
//  - cnt never exceeds DEB_CYCLES-1. No wrap-around is possible.
//  - Reset mid-operation: any pending RISE_CHK is abandoned with no pulse. If coin_raw is
//    still high when rst drops, it is treated as a new insertion: one pulse, same latency
//    measured from the first post-reset edge.
//  - Both outputs are register-driven: no combinational path from coin_raw to outputs.
// STRUCTURE
//  - Shared header coin_defs.vh holds:
//    - state encodings ST_IDLE, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK;
//    - the default DEB_CYCLES.
//    The classifier includes it for the same default.
//  - One sub-module, sync_2ff (1-bit two-flop synchroniser with sync active-high reset).
//    It is reused later for the start button.
//  - FSM next-state logic and the counter/output registers stay in coin_debounce.
// TESTING  (DEB_CYCLES=4, clock period 10 ns, all stimulus changes between edges)
//  1. rst=1 for 3 cycles, coin_raw=0 -> coin=0, coin_level=0 throughout and after release.
//  2. coin_raw 0->1, hold 12 cycles -> coin=1 for exactly 1 cycle, 6 edges after first sampling
//     edge; coin_level=1 same edge. Then coin_raw->0 -> coin_level=0 6 edges later, no pulse.
//  3. Glitch: coin_raw=1 for 3 cycles then 0 -> coin never 1, coin_level stays 0.
//  4. Bouncy press: coin_raw toggles every cycle for 6 cycles, then steady 1 for 10 ->
//     exactly one coin pulse, 6 edges after the first sample of the steady 1.
//  5. Release bounce: from HIGH, coin_raw=0 for 2 cycles then 1 ->
//     coin_level stays 1, no second pulse; total pulse count remains 1.
//  6. Mid-op reset: coin_raw=1, assert rst for 1 cycle while in RISE_CHK, keep coin_raw=1 ->
//     no pulse before reset; exactly one pulse 6 edges after rst deasserts.

Source files
------------

// File: rtl/coin_debounce_pkg.sv
//------------------------------------------------------------------------------
// Module  : coin_debounce_pkg
// Brief   : Shared state encodings and default debounce length for coin logic.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package coin_debounce_pkg;

    localparam int unsigned c_DEB_CYCLES_DEFAULT = 4;
    localparam int unsigned c_STATE_W            = 2;

    localparam logic [c_STATE_W-1:0] ST_IDLE     = 2'b00;
    localparam logic [c_STATE_W-1:0] ST_RISE_CHK = 2'b01;
    localparam logic [c_STATE_W-1:0] ST_HIGH     = 2'b10;
    localparam logic [c_STATE_W-1:0] ST_FALL_CHK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module  : sync_2ff
// Brief   : 1-bit two-flop synchroniser with synchronous active-high reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/coin_debounce.sv
//------------------------------------------------------------------------------
// Module  : coin_debounce
// Brief   : Synchronises and debounces the coin switch, one pulse per insertion.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module coin_debounce
    import coin_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = c_DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic coin_raw,
    output logic coin,
    output logic coin_level
);

    localparam int unsigned      CNT_W      = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic                 w_sync;
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_cnt_done;
    logic                 w_coin_next;
    logic                 w_level_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (coin_raw),
        .o_q (w_sync)
    );

    assign w_cnt_done = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            coin       <= 1'b0;
            coin_level <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            coin       <= w_coin_next;
            coin_level <= w_level_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sync) w_state_next = ST_RISE_CHK;
            end
            ST_RISE_CHK: begin
                if (!w_sync)         w_state_next = ST_IDLE;
                else if (w_cnt_done) w_state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (!w_sync) w_state_next = ST_FALL_CHK;
            end
            ST_FALL_CHK: begin
                // Release bounce returns to HIGH without re-arming the pulse.
                if (w_sync)          w_state_next = ST_HIGH;
                else if (w_cnt_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE:     if (w_sync)                 w_cnt_next = '0;
            ST_RISE_CHK: if (w_sync && !w_cnt_done)  w_cnt_next = r_cnt + 1'b1;
            ST_HIGH:     if (!w_sync)                w_cnt_next = '0;
            ST_FALL_CHK: if (!w_sync && !w_cnt_done) w_cnt_next = r_cnt + 1'b1;
            default:                                 w_cnt_next = '0;
        endcase
        w_coin_next  = (r_state == ST_RISE_CHK) && w_sync && w_cnt_done;
        w_level_next = (w_state_next == ST_HIGH) || (w_state_next == ST_FALL_CHK);
    end

endmodule

`default_nettype wire
